ysyx_25040111_icache_assoc: RTL and testbench
=============================================

// Module: ysyx_25040111_icache_assoc
// PURPOSE
//  Read-only, set-associative instruction cache between the IFU and the memory bus.
//  It is the successor to the direct-mapped icache and adds: WAYS-way associativity,
//  per-set round-robin replacement, fence.i invalidation, error abort and hit/miss strobes.
//  Refill uses one burst (or incrementing single beats) that fills a whole line.
// PARAMETERS
//  WAYS      2   ways per set; a power of two, 1..8 (1 = direct-mapped)
//  SETS_LS   3   log2(sets per way)
//  LINE_LS   4   log2(line size in bytes); >=2, so the line holds 2^(LINE_LS-2) words
//  BURST     1   1: one burst request, chaddr fixed; 0: chaddr += 4 after every beat
// PORTS
//  clock      in   1   system clock
//  reset      in   1   asynchronous, active-low reset
//  addr       in   32  fetch address; the IFU holds it stable from ifu_valid until ifu_ready
//  ifu_valid  in   1   fetch request
//  ifu_ready  out  1   one-cycle pulse: data is valid
//  data       out  32  fetched instruction word
//  fence_i    in   1   one-cycle pulse: invalidate every line
//  chburst    out  1   equals BURST
//  chvalid    out  1   refill request, held until the last beat
//  chready    in   1   a beat's data is valid on chdata
//  chaddr     out  32  refill address
//  chlen      out  8   beats minus 1 = 2^(LINE_LS-2)-1
//  chdata     in   32  beat data
//  err        in   1   bus error; aborts the refill
//  hit_o      out  1   one-cycle pulse on a lookup hit
//  miss_o     out  1   one-cycle pulse when a refill starts
// BEHAVIOUR
//  Address split: tag=addr[31:SETS_LS+LINE_LS], set=addr[SETS_LS+LINE_LS-1:LINE_LS], word=addr[LINE_LS-1:2].
//  Reset values: all valid bits=0, rr pointers=0, state=IDLE, data=0.
//    All control outputs are 0: ifu_ready, chvalid, hit_o, miss_o.
//  States: IDLE, REFILL, RESP.
//  IDLE, ifu_valid, hit in any way:
//    - data <= that way's word; ifu_ready=1 and hit_o=1 the next cycle.
//    - Hit latency is 1 cycle; stays in IDLE.
//    - No second response while ifu_ready is high (no back-to-back double pulse for the same request).
//  IDLE, ifu_valid, miss:
//    - miss_o=1.
//    - Victim = lowest-index invalid way; if none is invalid, victim = rr[set], and rr[set] <= rr[set]+1 (mod WAYS).
//    - chaddr <= {addr[31:LINE_LS], 0}; chvalid <= 1; beat counter = 0; go to REFILL.
//  REFILL:
//    - Each cycle with chready, chdata is written to victim word[cnt] and cnt increments.
//    - When BURST=0, chaddr += 4 on each beat.
//    - On the last beat (cnt==chlen) chvalid drops the next cycle, the tag is written, valid=1, go to RESP.
//  RESP: data <= victim word[addr word]; ifu_ready=1 for 1 cycle; go to IDLE.
//    - Miss latency = 1 (issue) + beats + 1 cycle after the last chready.
//  err, any state: chvalid <= 0; the victim valid stays 0 (it was cleared when the refill started).
//    - No ifu_ready pulse; go to IDLE. The IFU handles the trap.
//  fence_i in IDLE: all valid bits clear next cycle. rr pointers are unchanged.
//    - If fence_i arrives with a same-cycle ifu_valid, the fence takes priority and the request is treated as a miss.
//  fence_i in REFILL/RESP: a pending flag is latched; the refill completes and its word is returned;
//    - then all valids are cleared on the cycle RESP->IDLE.
//  reset asserted mid-refill: everything returns to reset values immediately; no later beats are written.
//  chready while not in REFILL is ignored.
//  The victim valid bit is cleared when the refill starts, so a partial line is never hit.
// TESTING
//  1 cold miss: fetch 0x8000_0000, 4 beats 0xA0..0xA3 -> miss_o=1, chaddr=0x8000_0000, chlen=3, ifu_ready 1 cycle after beat 3, data=0xA0.
//  2 hit: then fetch 0x8000_0008 -> hit_o=1, ifu_ready next cycle, data=0xA2, no chvalid.
//  3 conflict, WAYS=2: fill 0x8000_0000, 0x8000_0080, 0x8000_0100 (same set 0) -> third evicts way0 (rr); 0x8000_0080 still hits, 0x8000_0000 misses.
//  4 fence: fence_i after test 2, then fetch 0x8000_0008 -> miss_o=1, refill issued.
//  5 error: assert err on beat 1 -> chvalid low next cycle, no ifu_ready; a retry of the same addr misses again.
//  6 BURST=0: beats go to chaddr 0x..00,04,08,0C; reset asserted at beat 2 -> all outputs 0 and the line is invalid.

Source files
------------

// File: rtl/ysyx_25040111_icache_assoc.sv
// Read-only set-associative instruction cache with round-robin replacement,
// fence.i invalidation, bus-error abort and hit/miss strobes.
module ysyx_25040111_icache_assoc #(
    parameter int WAYS    = 2,
    parameter int SETS_LS = 3,
    parameter int LINE_LS = 4,
    parameter int BURST   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        ifu_valid,
    output logic        ifu_ready,
    output logic [31:0] data,
    input  logic        fence_i,
    output logic        chburst,
    output logic        chvalid,
    input  logic        chready,
    output logic [31:0] chaddr,
    output logic [7:0]  chlen,
    input  logic [31:0] chdata,
    input  logic        err,
    output logic        hit_o,
    output logic        miss_o
);
    localparam int WORDS = 1 << (LINE_LS - 2);
    localparam int SETS  = 1 << SETS_LS;
    localparam int TAG_W = 32 - SETS_LS - LINE_LS;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W = (LINE_LS > 2) ? LINE_LS - 2 : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [31:0]      data_mem [WAYS][SETS][WORDS];

    state_t                       state_q, state_d;
    logic [WAYS-1:0][SETS-1:0]    valid_q, valid_d, valid_eff;
    logic [SETS-1:0][WAY_W-1:0]   rr_q, rr_d;
    logic [WAY_W-1:0]             victim_q, victim_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [31:0]                  chaddr_q, chaddr_d;
    logic [31:0]                  data_q, data_d;
    logic                         chvalid_q, chvalid_d;
    logic                         ifu_ready_q, ifu_ready_d;
    logic                         hit_q, hit_d;
    logic                         miss_q, miss_d;
    logic                         fence_pend_q, fence_pend_d;

    logic [TAG_W-1:0]   tag;
    logic [SETS_LS-1:0] set_idx;
    logic [CNT_W-1:0]   word_idx;
    logic               hit_any, inv_any, we_beat;
    logic [WAY_W-1:0]   hit_way, inv_way, victim_sel, rr_next;

    assign tag      = addr[31:SETS_LS+LINE_LS];
    assign set_idx  = addr[SETS_LS+LINE_LS-1:LINE_LS];
    assign word_idx = (LINE_LS > 2) ? CNT_W'(addr >> 2) : '0;

    // A fence in IDLE wins over a same-cycle lookup: it sees an empty cache.
    always_comb begin
        valid_eff = (state_q == IDLE && fence_i) ? '0 : valid_q;
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_any   = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_eff[w][set_idx] && tag_mem[w][set_idx] == tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_eff[w][set_idx]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        victim_sel = inv_any ? inv_way : rr_q[set_idx];
        rr_next    = (WAYS > 1) ? rr_q[set_idx] + WAY_W'(1) : '0;
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        victim_d     = victim_q;
        cnt_d        = cnt_q;
        chaddr_d     = chaddr_q;
        chvalid_d    = chvalid_q;
        data_d       = data_q;
        ifu_ready_d  = 1'b0;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        we_beat      = 1'b0;
        fence_pend_d = fence_pend_q | (fence_i && state_q != IDLE);
        case (state_q)
            IDLE: begin
                valid_d = valid_eff;
                if (ifu_valid && !ifu_ready_q) begin
                    if (hit_any) begin
                        data_d      = data_mem[hit_way][set_idx][word_idx];
                        ifu_ready_d = 1'b1;
                        hit_d       = 1'b1;
                    end else begin
                        miss_d                     = 1'b1;
                        victim_d                   = victim_sel;
                        valid_d[victim_sel][set_idx] = 1'b0;
                        if (!inv_any) rr_d[set_idx] = rr_next;
                        chaddr_d  = {addr[31:LINE_LS], {LINE_LS{1'b0}}};
                        chvalid_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = REFILL;
                    end
                end
            end
            REFILL: begin
                if (err) begin
                    chvalid_d = 1'b0;
                    state_d   = IDLE;
                    if (fence_pend_d) valid_d = '0;
                    fence_pend_d = 1'b0;
                end else if (chready) begin
                    we_beat = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (BURST == 0) chaddr_d = chaddr_q + 32'd4;
                    if (cnt_q == LAST_BEAT) begin
                        chvalid_d                  = 1'b0;
                        valid_d[victim_q][set_idx] = 1'b1;
                        state_d                    = RESP;
                    end
                end
            end
            RESP: begin
                if (!err) begin
                    data_d      = data_mem[victim_q][set_idx][word_idx];
                    ifu_ready_d = 1'b1;
                end
                if (fence_pend_d) valid_d = '0;
                fence_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            rr_q         <= '0;
            victim_q     <= '0;
            cnt_q        <= '0;
            chaddr_q     <= '0;
            chvalid_q    <= 1'b0;
            data_q       <= '0;
            ifu_ready_q  <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            fence_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
            victim_q     <= victim_d;
            cnt_q        <= cnt_d;
            chaddr_q     <= chaddr_d;
            chvalid_q    <= chvalid_d;
            data_q       <= data_d;
            ifu_ready_q  <= ifu_ready_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            fence_pend_q <= fence_pend_d;
        end
    end

    // Line storage; the tag is rewritten each beat but only trusted once valid is set.
    always_ff @(posedge clock) begin
        if (we_beat) begin
            data_mem[victim_q][set_idx][cnt_q] <= chdata;
            tag_mem[victim_q][set_idx]         <= tag;
        end
    end

    assign ifu_ready = ifu_ready_q;
    assign data      = data_q;
    assign chburst   = (BURST != 0);
    assign chvalid   = chvalid_q;
    assign chaddr    = chaddr_q;
    assign chlen     = 8'(WORDS - 1);
    assign hit_o     = hit_q;
    assign miss_o    = miss_q;
endmodule

// File: tb/tb_ysyx_25040111_icache_assoc.sv
// Directed bench for the associative icache: a burst instance for the main flow
// and a single-beat instance for address stepping and mid-refill reset.
module tb_ysyx_25040111_icache_assoc;
    logic        clock = 1'b0;
    logic        rst_n, rst0_n;
    logic [31:0] addr, addr0, chdata, chdata0, data, data0, chaddr, chaddr0;
    logic        ifu_valid, ifu_valid0, fence_i, fence_i0, chready, chready0, err, err0;
    logic        ifu_ready, ifu_ready0, chburst, chburst0, chvalid, chvalid0;
    logic        hit_o, hit0, miss_o, miss0;
    logic [7:0]  chlen, chlen0;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q[$];
    bit          saw, got0;

    always #5 clock = ~clock;

    ysyx_25040111_icache_assoc #(.WAYS(2), .SETS_LS(3), .LINE_LS(4), .BURST(1)) u_dut (
        .clock(clock), .reset(rst_n), .addr(addr), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
        .data(data), .fence_i(fence_i), .chburst(chburst), .chvalid(chvalid), .chready(chready),
        .chaddr(chaddr), .chlen(chlen), .chdata(chdata), .err(err), .hit_o(hit_o), .miss_o(miss_o)
    );

    ysyx_25040111_icache_assoc #(.WAYS(2), .SETS_LS(3), .LINE_LS(4), .BURST(0)) u_dut0 (
        .clock(clock), .reset(rst0_n), .addr(addr0), .ifu_valid(ifu_valid0), .ifu_ready(ifu_ready0),
        .data(data0), .fence_i(fence_i0), .chburst(chburst0), .chvalid(chvalid0), .chready(chready0),
        .chaddr(chaddr0), .chlen(chlen0), .chdata(chdata0), .err(err0), .hit_o(hit0), .miss_o(miss0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called on the negedge where ifu_ready is expected after exp_wait more cycles.
    task automatic wait_resp(input int exp_wait);
        bit got = 0;
        int waited = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (ifu_ready) begin
                got = 1;
                waited = i;
            end else @(negedge clock);
        end
        chk("resp_seen", 32'(got), 1);
        if (got) begin
            chk("resp_latency", waited, exp_wait);
            chk("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) chk("resp_data", data, sb_q.pop_front());
            ifu_valid = 0;
            @(negedge clock);
            chk("ready_single_pulse", 32'(ifu_ready), 0);
        end else begin
            ifu_valid = 0;
            sb_q.delete();
        end
    endtask

    task automatic fetch_a(input logic [31:0] a, input bit exp_miss, input logic [31:0] line_base,
                           input logic [31:0] exp_data, input bit fence_same, input int fence_beat);
        logic [31:0] line_addr;
        @(negedge clock);
        addr = a;
        ifu_valid = 1;
        fence_i = fence_same;
        sb_q.push_back(exp_data);
        @(negedge clock);
        fence_i = 0;
        chk("miss_o", 32'(miss_o), 32'(exp_miss));
        chk("hit_o", 32'(hit_o), 32'(!exp_miss));
        chk("chvalid_issue", 32'(chvalid), 32'(exp_miss));
        if (exp_miss) begin
            line_addr = {a[31:4], 4'h0};
            chk("chaddr", chaddr, line_addr);
            chk("chlen", 32'(chlen), 3);
            chk("chburst", 32'(chburst), 1);
            for (int i = 0; i < 4; i++) begin
                chready = 1;
                chdata = line_base + 32'(i);
                fence_i = (i == fence_beat);
                @(negedge clock);
            end
            chready = 0;
            fence_i = 0;
            chk("chvalid_drop", 32'(chvalid), 0);
            chk("no_early_ready", 32'(ifu_ready), 0);
            wait_resp(1);
        end else begin
            wait_resp(0);
        end
    endtask

    initial begin
        rst_n = 0; rst0_n = 0;
        addr = 0; ifu_valid = 0; fence_i = 0; chready = 0; chdata = 0; err = 0;
        addr0 = 0; ifu_valid0 = 0; fence_i0 = 0; chready0 = 0; chdata0 = 0; err0 = 0;
        repeat (2) @(negedge clock);
        chk("rst_ifu_ready", 32'(ifu_ready), 0);
        chk("rst_chvalid", 32'(chvalid), 0);
        chk("rst_hit", 32'(hit_o), 0);
        chk("rst_miss", 32'(miss_o), 0);
        chk("rst_data", data, 0);
        rst_n = 1; rst0_n = 1;

        // cold miss, then hit in the same line
        fetch_a(32'h8000_0000, 1, 32'hA0, 32'hA0, 0, -1);
        fetch_a(32'h8000_0008, 0, 0, 32'hA2, 0, -1);

        // stray chready outside a refill must not disturb contents
        @(negedge clock);
        chready = 1; chdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chready = 0;
        chk("stray_chready_chvalid", 32'(chvalid), 0);
        fetch_a(32'h8000_0008, 0, 0, 32'hA2, 0, -1);

        // fence in IDLE invalidates everything
        @(negedge clock);
        fence_i = 1;
        @(negedge clock);
        fence_i = 0;
        fetch_a(32'h8000_0008, 1, 32'hA0, 32'hA2, 0, -1);

        // set-0 conflicts: fill way1, then rr evicts way0, then way1
        fetch_a(32'h8000_0080, 1, 32'hB0, 32'hB0, 0, -1);
        fetch_a(32'h8000_0100, 1, 32'hC0, 32'hC0, 0, -1);
        fetch_a(32'h8000_0084, 0, 0, 32'hB1, 0, -1);
        fetch_a(32'h8000_0000, 1, 32'hA0, 32'hA0, 0, -1);
        fetch_a(32'h8000_010C, 0, 0, 32'hC3, 0, -1);
        fetch_a(32'h8000_0080, 1, 32'hB0, 32'hB0, 0, -1);
        fetch_a(32'h8000_0004, 0, 0, 32'hA1, 0, -1);

        // fence with a same-cycle request: the resident line must miss
        fetch_a(32'h8000_0004, 1, 32'hD0, 32'hD1, 1, -1);
        fetch_a(32'h8000_0084, 1, 32'hB0, 32'hB1, 0, -1);

        // fence during a refill: word still returned, then cache flushed
        fetch_a(32'h8000_0028, 1, 32'h50, 32'h52, 0, 1);
        fetch_a(32'h8000_0004, 1, 32'hD0, 32'hD1, 0, -1);

        // bus error on beat 1 aborts without a response; retry misses again
        @(negedge clock);
        addr = 32'h8000_0040; ifu_valid = 1;
        @(negedge clock);
        chk("err_miss_o", 32'(miss_o), 1);
        chready = 1; chdata = 32'hE0;
        @(negedge clock);
        chdata = 32'hE1; err = 1;
        @(negedge clock);
        err = 0; chready = 0; ifu_valid = 0;
        chk("err_chvalid_drop", 32'(chvalid), 0);
        saw = 0;
        repeat (5) begin
            saw |= ifu_ready;
            @(negedge clock);
        end
        chk("err_no_ready", 32'(saw), 0);
        fetch_a(32'h8000_0040, 1, 32'hE0, 32'hE0, 0, -1);

        // single-beat addressing with a reset landing on beat 2
        @(negedge clock);
        addr0 = 32'h8000_0040; ifu_valid0 = 1;
        @(negedge clock);
        chk("b_chburst", 32'(chburst0), 0);
        chk("b_miss0", 32'(miss0), 1);
        for (int i = 0; i < 2; i++) begin
            chk("b_chaddr_step", chaddr0, 32'h8000_0040 + 32'(4 * i));
            chready0 = 1; chdata0 = 32'hF0 + 32'(i);
            @(negedge clock);
        end
        chk("b_chaddr_beat2", chaddr0, 32'h8000_0048);
        rst0_n = 0;
        #1;
        chk("b_rst_ifu_ready", 32'(ifu_ready0), 0);
        chk("b_rst_chvalid", 32'(chvalid0), 0);
        chk("b_rst_hit", 32'(hit0), 0);
        chk("b_rst_miss", 32'(miss0), 0);
        chk("b_rst_data", data0, 0);
        chk("b_rst_chaddr", chaddr0, 0);
        chready0 = 0; ifu_valid0 = 0;
        @(negedge clock);
        rst0_n = 1;
        @(negedge clock);
        addr0 = 32'h8000_0040; ifu_valid0 = 1;
        sb_q.push_back(32'h90);
        @(negedge clock);
        chk("b_line_invalid_miss", 32'(miss0), 1);
        for (int i = 0; i < 4; i++) begin
            chk("b_chaddr_full", chaddr0, 32'h8000_0040 + 32'(4 * i));
            chready0 = 1; chdata0 = 32'h90 + 32'(i);
            @(negedge clock);
        end
        chready0 = 0;
        got0 = 0;
        for (int i = 0; i < 12 && !got0; i++) begin
            if (ifu_ready0) got0 = 1;
            else @(negedge clock);
        end
        chk("b_resp_seen", 32'(got0), 1);
        if (sb_q.size() > 0) chk("b_resp_data", data0, sb_q.pop_front());
        ifu_valid0 = 0;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
